// File: rtl/ntt_ctrl_pkg.sv
// Shared types and constants for the 8-point NTT/INTT stream sequencer.
package ntt_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        UNLOAD,
        DONE
    } state_t;

    localparam logic [1:0] RADIX_1ST     = 2'd0;
    localparam logic [1:0] RADIX_2ND     = 2'd1;
    localparam logic [1:0] RADIX_3RD     = 2'd2;
    localparam logic [1:0] RADIX_ILLEGAL = 2'd3;

    localparam logic NTT_MODE  = 1'b0;
    localparam logic INTT_MODE = 1'b1;

    function automatic logic is_busy_state(input state_t s);
        return (s == LOAD) || (s == SETTLE) || (s == UNLOAD);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Shared phase counter: clears on request, counts up while enabled and flags
// the last count before the supplied limit.
module phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_terminal
);

    logic [CNT_W-1:0] r_count;

    // The look-ahead value lets the owner register outputs that line up with the count.
    always_comb begin
        o_count_next = r_count;
        if (i_clear) begin
            o_count_next = '0;
        end else if (i_enable) begin
            o_count_next = r_count + CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == (i_limit - CNT_W'(1)));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_next;
        end
    end

endmodule

// File: rtl/ntt_stream_controller.sv
// Job sequencer for the 8-point radix-2 NTT/INTT core (load/settle/unload).
// Optional 16-bit completed-frame counter under macro NTT_CTRL_FRAME_CNT_EN.
module ntt_stream_controller
    import ntt_ctrl_pkg::*;
#(
    parameter int POINTS        = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int TW_ADDR_W     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           cfg_radix_mode,
    input  logic                 cfg_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 in_ready,
    output logic                 streaming_mode,
    output logic [1:0]           radix_mode,
    output logic                 mode,
    output logic [TW_ADDR_W-1:0] tw_addr,
    output logic                 out_valid,
    output logic [2:0]           out_index
`ifdef NTT_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_count
`endif
);

    localparam int CNT_W = $clog2(POINTS) + 1;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_can_start;
    logic             w_accept;
    logic             w_reject;
    logic             w_clear;
    logic             w_enable;
    logic             w_terminal;
    logic             w_mode_next;
    logic [CNT_W-1:0] w_limit;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_can_start = (r_state == IDLE) || (r_state == DONE);
    assign w_accept    = w_can_start && start && (cfg_radix_mode != RADIX_ILLEGAL);
    assign w_reject    = w_can_start && start && (cfg_radix_mode == RADIX_ILLEGAL);
    assign w_limit     = (r_state == SETTLE) ? CNT_W'(SETTLE_CYCLES) : CNT_W'(POINTS);
    assign w_enable    = is_busy_state(r_state);
    assign w_clear     = (w_next_state != r_state);
    assign w_mode_next = w_accept ? cfg_mode : mode;

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = LOAD;
            LOAD:    if (w_terminal) w_next_state = SETTLE;
            SETTLE:  if (w_terminal) w_next_state = UNLOAD;
            UNLOAD:  if (w_terminal) w_next_state = DONE;
            DONE:    w_next_state = w_accept ? LOAD : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_enable     (w_enable),
        .i_limit      (w_limit),
        .o_count_next (w_cnt_next),
        .o_terminal   (w_terminal)
    );

    // Outputs are registered from the next state/count so they coincide with the phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
            in_ready       <= 1'b0;
            streaming_mode <= 1'b0;
            radix_mode     <= RADIX_3RD;
            mode           <= NTT_MODE;
            tw_addr        <= '0;
            out_valid      <= 1'b0;
            out_index      <= '0;
        end else begin
            r_state        <= w_next_state;
            busy           <= is_busy_state(w_next_state);
            done           <= (w_next_state == DONE);
            cfg_err        <= w_reject;
            in_ready       <= (w_next_state == LOAD);
            streaming_mode <= (w_next_state == LOAD);
            mode           <= w_mode_next;
            if (w_accept) begin
                radix_mode <= cfg_radix_mode;
            end
            tw_addr        <= (w_next_state == LOAD)
                            ? TW_ADDR_W'(w_cnt_next) + (w_mode_next ? TW_ADDR_W'(POINTS) : '0)
                            : '0;
            out_valid      <= (w_next_state == UNLOAD);
            out_index      <= (w_next_state == UNLOAD) ? w_cnt_next[2:0] : 3'd0;
        end
    end

`ifdef NTT_CTRL_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (done) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_ntt_stream_controller.sv
// Randomized self-checking bench for ntt_stream_controller against a job-timeline model.
module tb_ntt_stream_controller;

    localparam int POINTS = 8;
    localparam int S      = 1;
    localparam int TW_W   = 4;
    localparam int DONE_K = 2 * POINTS + S + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      cfg_radix_mode;
    logic            cfg_mode;
    logic            busy, done, cfg_err, in_ready, streaming_mode, mode;
    logic [1:0]      radix_mode;
    logic [TW_W-1:0] tw_addr;
    logic            out_valid;
    logic [2:0]      out_index;
`ifdef NTT_CTRL_FRAME_CNT_EN
    logic [15:0]     frame_count;
`endif

    ntt_stream_controller #(
        .POINTS        (POINTS),
        .SETTLE_CYCLES (S),
        .TW_ADDR_W     (TW_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cfg_radix_mode (cfg_radix_mode),
        .cfg_mode       (cfg_mode),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .in_ready       (in_ready),
        .streaming_mode (streaming_mode),
        .radix_mode     (radix_mode),
        .mode           (mode),
        .tw_addr        (tw_addr),
        .out_valid      (out_valid),
        .out_index      (out_index)
`ifdef NTT_CTRL_FRAME_CNT_EN
        ,
        .frame_count    (frame_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_k is the cycle number within the current job (0 = no job running).
    int m_k      = 0;
    int m_radix  = 2;
    int m_mode   = 0;
    int m_err    = 0;
    int m_frames = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit can_start;
        if (reset) begin
            m_k = 0; m_radix = 2; m_mode = 0; m_err = 0; m_frames = 0;
        end else begin
            if (m_k == DONE_K) m_frames = (m_frames + 1) & 16'hFFFF;
            can_start = (m_k == 0) || (m_k == DONE_K);
            m_err = 0;
            if (can_start && start && cfg_radix_mode != 2'd3) begin
                m_k = 1; m_radix = cfg_radix_mode; m_mode = cfg_mode;
            end else if (can_start) begin
                m_k = 0;
                if (start) m_err = 1;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic compare_all();
        bit ld, ul;
        int exp_tw, exp_idx;
        ld      = (m_k >= 1) && (m_k <= POINTS);
        ul      = (m_k >= POINTS + S + 1) && (m_k <= 2 * POINTS + S);
        exp_tw  = ld ? (m_k - 1 + (m_mode ? POINTS : 0)) : 0;
        exp_idx = ul ? (m_k - (POINTS + S + 1)) : 0;
        check("busy",           busy,           (m_k >= 1) && (m_k < DONE_K));
        check("done",           done,           m_k == DONE_K);
        check("cfg_err",        cfg_err,        m_err);
        check("streaming_mode", streaming_mode, ld);
        check("in_ready",       in_ready,       ld);
        check("radix_mode",     radix_mode,     m_radix);
        check("mode",           mode,           m_mode);
        check("tw_addr",        tw_addr,        exp_tw);
        check("out_valid",      out_valid,      ul);
        check("out_index",      out_index,      exp_idx);
`ifdef NTT_CTRL_FRAME_CNT_EN
        check("frame_count",    frame_count,    m_frames);
`endif
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; cfg_radix_mode = 2'd0; cfg_mode = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Basic NTT job with full radix depth; measure start-to-done latency.
        cfg_radix_mode = 2'd2; cfg_mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("latency", n, 17 + S);
        step();

        // INTT job with cfg inputs toggling mid-job.
        cfg_radix_mode = 2'd0; cfg_mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < DONE_K + 2; i++) begin
            cfg_radix_mode = 2'($urandom_range(0, 3));
            cfg_mode       = 1'($urandom_range(0, 1));
            step();
        end

        // Illegal radix request.
        cfg_radix_mode = 2'd3; cfg_mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("reject_pulse", cfg_err, 1'b1);
        step();
        step();

        // Start held high: back-to-back jobs, starts during busy ignored.
        start = 1'b1; cfg_radix_mode = 2'd1;
        for (int i = 0; i < 3 * DONE_K + 2; i++) begin
            cfg_mode = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        for (int i = 0; i < DONE_K + 1; i++) step();

        // Reset in the 4th unload cycle, then a normal job.
        cfg_radix_mode = 2'd2; cfg_mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (m_k != POINTS + S + 4 && n < 40) begin
            step();
            n++;
        end
        check("reach_unload4", m_k, POINTS + S + 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("no_done_after_reset", done, 1'b0);
        start = 1'b1; cfg_mode = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < DONE_K + 2; i++) step();

        // Random traffic with occasional reset and illegal configs.
        for (int i = 0; i < 1500; i++) begin
            start          = ($urandom_range(0, 3) == 0);
            cfg_radix_mode = 2'($urandom_range(0, 3));
            cfg_mode       = 1'($urandom_range(0, 1));
            reset          = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; start = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_stream_controller.md
# ntt_stream_controller

Sequencer for the 8-point combined radix-2 NTT/INTT core. It accepts a job request from the host and latches the job configuration (radix depth, NTT/INTT). It then drives the core's `streaming_mode`, `radix_mode` and `mode` inputs through load, settle and unload phases. It also generates twiddle-ROM addresses for the three weight streams and marks valid output samples, so the host only handles a start/done handshake and raw sample streams.

## Interface
Parameters:
- `POINTS`, 8: samples per frame; must match the core's serial/parallel depth.
- `SETTLE_CYCLES`, 1: cycles between the last load cycle and the first unload cycle (range 1–7).
- `TW_ADDR_W`, 4: twiddle-ROM address width.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE or DONE.
- `cfg_radix_mode`  in  2  0 = stage 1 only, 1 = stages 1–2, 2 = full 3-stage; 3 is illegal.
- `cfg_mode`  in  1  0 = NTT, 1 = INTT.
- `busy`  out  1  high in LOAD, SETTLE and UNLOAD.
- `done`  out  1  one-cycle pulse on job completion.
- `cfg_err`  out  1  one-cycle pulse when a start is rejected.
- `in_ready`  out  1  host must present one input sample per cycle while high.
- `streaming_mode`  out  1  to core; 1 only in LOAD.
- `radix_mode`  out  2  to core; latched job value.
- `mode`  out  1  to core; latched job value.
- `tw_addr`  out  TW_ADDR_W  twiddle-ROM address feeding all three weight streams.
- `out_valid`  out  1  core output stream carries a valid sample.
- `out_index`  out  3  index of the current output sample, 0..7.

## Operation
- States and transitions:
  - IDLE → LOAD on an accepted start.
  - LOAD (POINTS cycles) → SETTLE.
  - SETTLE (SETTLE_CYCLES cycles) → UNLOAD.
  - UNLOAD (POINTS cycles) → DONE.
  - DONE (1 cycle) → LOAD if an accepted start is present, otherwise → IDLE.
- Accepting a start: `start`=1 in IDLE/DONE with `cfg_radix_mode`≠3. `cfg_radix_mode` and `cfg_mode` are captured into `radix_mode`/`mode` on the same edge.
- Rejecting a start: `start`=1 in IDLE/DONE with `cfg_radix_mode`=3.
  - `cfg_err` pulses on the next cycle.
  - State stays IDLE; latched configuration is unchanged.
- `start` in LOAD/SETTLE/UNLOAD is ignored; no error is flagged.
- Configuration inputs are ignored except on an accepted-start edge; they may change freely mid-job.
- A single phase counter counts up from 0 in LOAD and in UNLOAD and is cleared on every state change.
- `tw_addr` = counter + (`mode` ? POINTS : 0) during LOAD; held at 0 otherwise.
- `out_index` = counter during UNLOAD; 0 otherwise.
- `in_ready` equals `streaming_mode`.

## Timing
- Reset values: state IDLE, counter 0, `busy`=0, `done`=0, `cfg_err`=0, `in_ready`=0, `streaming_mode`=0, `radix_mode`=2, `mode`=0, `tw_addr`=0, `out_valid`=0, `out_index`=0.
- All outputs are registered.
- Job timeline, with an accepted start sampled at edge t:
  - Cycles t+1..t+8: LOAD.
  - Next SETTLE_CYCLES cycles: SETTLE.
  - Next 8 cycles: UNLOAD, `out_valid`=1.
  - Next cycle: DONE, `done`=1.
- Total latency from the start edge to `done` is 17+SETTLE_CYCLES cycles.
- Back-to-back: a start accepted during DONE makes the next cycle LOAD, leaving no IDLE gap.
- A reset asserted in any state returns all outputs to reset values on the next edge. A partial frame is discarded; `done` does not pulse.
- `reset` and `start` high together: `reset` wins.

## Configuration
- Macro `NTT_CTRL_FRAME_CNT_EN`.
- When defined:
  - Adds output `frame_count` (16 bits, reset 0).
  - It increments on every `done` pulse and wraps 0xFFFF → 0x0000.
- When undefined: the port and its counter do not exist; all other behaviour is identical.

## Structure
- Package `ntt_ctrl_pkg`:
  - State enum: IDLE, LOAD, SETTLE, UNLOAD, DONE.
  - Radix constants `RADIX_1ST`=0, `RADIX_2ND`=1, `RADIX_3RD`=2, `RADIX_ILLEGAL`=3.
  - `NTT_MODE`=0, `INTT_MODE`=1.
- Sub-module `phase_counter`:
  - Clear and enable inputs.
  - Up-count from 0; parameterised terminal-count flag at a given limit.
  - One instance serves both LOAD and UNLOAD; SETTLE uses the same instance with limit SETTLE_CYCLES.

## Test plan
- Reset then start with `cfg_radix_mode`=2 and `cfg_mode`=0 (SETTLE_CYCLES=1) → `streaming_mode`=1 for exactly 8 cycles; `tw_addr` 0..7; `out_valid` for 8 cycles with `out_index` 0..7; `done` at cycle 18 after the start edge.
- INTT job (`cfg_mode`=1, `cfg_radix_mode`=0) → `tw_addr` 8..15 during LOAD; `mode`=1 and `radix_mode`=0 held for the whole job, even if the cfg inputs toggle mid-job.
- Start with `cfg_radix_mode`=3 → `cfg_err` pulses once, `busy` stays 0, `radix_mode` keeps its previous value.
- `start` held high continuously → jobs run back-to-back with LOAD directly after each DONE; starts during `busy` are ignored; `frame_count` (macro on) advances by 1 per `done`.
- Reset asserted in the 4th UNLOAD cycle → next cycle all outputs are at reset values and no `done` occurs; a subsequent start runs a normal full job.
